// File: rtl/rv32_pkg.sv
// Shared writeback-source identifiers and datapath widths for the decode-stage
// register-file write scheduler.
package rv32_pkg;

  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_LSU = 2'd1,
    WB_SRC_MDU = 2'd2,
    WB_SRC_FPU = 2'd3
  } wb_src_e;

  localparam int NUM_WB_SRC = 4;
  localparam int REG_AW     = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

endpackage

// File: rtl/rv32_d_rr_arbiter.sv
// Round-robin arbiter: the search for a requester starts at ptr and wraps.
// The grant is one-hot, or zero when nothing is requesting.
module rv32_d_rr_arbiter
  import rv32_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv32_d_rf_write_scheduler.sv
// Arbitrates the writeback sources onto the single integer RF write port, and keeps a
// pending/owner scoreboard so decode can stall on RAW and WAW hazards.
module rv32_d_rf_write_scheduler
  import rv32_pkg::*;
#(
  parameter int N_REQ  = NUM_WB_SRC,
  parameter int UNIT_W = $clog2(N_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    issue_valid_i,
  input  logic [REG_AW-1:0]       issue_rd_i,
  input  logic [UNIT_W-1:0]       issue_unit_i,
  output logic                    issue_ready_o,
  input  logic [REG_AW-1:0]       rs1_i,
  input  logic [REG_AW-1:0]       rs2_i,
  output logic                    rs1_busy_o,
  output logic                    rs2_busy_o,
  input  logic [N_REQ-1:0]        wr_valid_i,
  input  logic [N_REQ*REG_AW-1:0] wr_rd_i,
  input  logic [N_REQ*XLEN-1:0]   wr_data_i,
  output logic [N_REQ-1:0]        wr_ready_o,
  output logic                    rf_write_enable_o,
  output logic [REG_AW-1:0]       rf_write_address_o,
  output logic [XLEN-1:0]         rf_write_data_o
);

  logic [NUM_REGS-1:0] pending_reg;
  logic [UNIT_W-1:0]   owner_reg [NUM_REGS];
  logic [UNIT_W-1:0]   rr_ptr_reg;

  logic [N_REQ-2:0]    rr_grant;
  logic [N_REQ-1:0]    grant;
  logic                win_any;
  logic [UNIT_W-1:0]   win_id;
  logic [REG_AW-1:0]   win_rd;
  logic [XLEN-1:0]     win_data;
  logic                win_we;
  logic                issue_fire;

  // rr_ptr holds a source id (1..N_REQ-1); the arbiter indexes its requesters from 0.
  rv32_d_rr_arbiter #(
    .N     (N_REQ - 1),
    .PTR_W (UNIT_W)
  ) u_rr_arbiter (
    .req   (wr_valid_i[N_REQ-1:1]),
    .ptr   (rr_ptr_reg - UNIT_W'(1)),
    .grant (rr_grant)
  );

  always_comb begin
    grant = '0;
    if (!rst_i) begin
      if (wr_valid_i[int'(WB_SRC_ALU)]) grant[int'(WB_SRC_ALU)] = 1'b1;
      else                              grant = {rr_grant, 1'b0};
    end
  end

  // The winner's rd/data mux; address and data stay zero when nothing is granted.
  always_comb begin
    win_id   = '0;
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_id   = UNIT_W'(i);
        win_rd   = wr_rd_i[REG_AW*i +: REG_AW];
        win_data = wr_data_i[XLEN*i +: XLEN];
      end
    end
  end

  assign win_any = |grant;
  assign win_we  = win_any && (win_rd != '0);

  assign wr_ready_o         = grant;
  assign rf_write_enable_o  = win_we;
  assign rf_write_address_o = win_rd;
  assign rf_write_data_o    = win_data;

  // Start-of-cycle pending state only: a same-cycle clear still stalls for one cycle.
  assign issue_ready_o = !rst_i && ((issue_rd_i == '0) || !pending_reg[issue_rd_i]);
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

  assign rs1_busy_o = !rst_i && (rs1_i != '0) && pending_reg[rs1_i];
  assign rs2_busy_o = !rst_i && (rs2_i != '0) && pending_reg[rs2_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_reg <= UNIT_W'(1);
    end else if (win_any && (win_id != '0)) begin
      rr_ptr_reg <= (win_id == UNIT_W'(N_REQ - 1)) ? UNIT_W'(1) : win_id + UNIT_W'(1);
    end
  end

  // Only the owning unit's write retires an entry; other writes leave it pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_reg <= '0;
      for (int r = 0; r < NUM_REGS; r++) owner_reg[r] <= '0;
    end else begin
      if (win_we && (owner_reg[win_rd] == win_id)) pending_reg[win_rd] <= 1'b0;
      if (issue_fire) begin
        pending_reg[issue_rd_i] <= 1'b1;
        owner_reg[issue_rd_i]   <= issue_unit_i;
      end
      pending_reg[0] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32_d_rf_write_scheduler.sv
// Directed bench for the RF write scheduler: reset, arbitration order, scoreboard
// RAW/WAW stalls, owner-qualified clears and x0 handling.
module tb_rv32_d_rf_write_scheduler;

  logic         clk;
  logic         rst;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic [1:0]   issue_unit;
  logic         issue_ready;
  logic [4:0]   rs1;
  logic [4:0]   rs2;
  logic         rs1_busy;
  logic         rs2_busy;
  logic [3:0]   wr_valid;
  logic [19:0]  wr_rd;
  logic [127:0] wr_data;
  logic [3:0]   wr_ready;
  logic         rf_we;
  logic [4:0]   rf_addr;
  logic [31:0]  rf_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf_model [32];

  rv32_d_rf_write_scheduler dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .issue_valid_i      (issue_valid),
    .issue_rd_i         (issue_rd),
    .issue_unit_i       (issue_unit),
    .issue_ready_o      (issue_ready),
    .rs1_i              (rs1),
    .rs2_i              (rs2),
    .rs1_busy_o         (rs1_busy),
    .rs2_busy_o         (rs2_busy),
    .wr_valid_i         (wr_valid),
    .wr_rd_i            (wr_rd),
    .wr_data_i          (wr_data),
    .wr_ready_o         (wr_ready),
    .rf_write_enable_o  (rf_we),
    .rf_write_address_o (rf_addr),
    .rf_write_data_o    (rf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: writes on the falling edge like the real array.
  always @(negedge clk) if (rf_we) rf_model[rf_addr] <= rf_data;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] d);
    wr_rd[5*i +: 5]    = rd;
    wr_data[32*i +: 32] = d;
  endtask

  task automatic idle;
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_unit  = '0;
    rs1         = '0;
    rs2         = '0;
    wr_valid    = '0;
    wr_rd       = '0;
    wr_data     = '0;
  endtask

  task automatic test_reset;
    idle();
    rst         = 1'b1;
    wr_valid    = 4'b1111;
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    rs1         = 5'd3;
    rs2         = 5'd3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (wr_ready !== 4'b0000) begin bad++; $display("FAIL reset_wr_ready: got %b expected 0000", wr_ready); end
      total++;
      if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b expected 0", rf_we); end
      total++;
      if (issue_ready !== 1'b0) begin bad++; $display("FAIL reset_issue_ready: got %b expected 0", issue_ready); end
      total++;
      if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL reset_busy: got %b expected 00", {rs1_busy, rs2_busy}); end
      tick();
    end
    issue_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (wr_ready !== 4'b0001) begin bad++; $display("FAIL reset_release_grant: got %b expected 0001", wr_ready); end
    total++;
    if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b expected 0", rs1_busy); end
    $display("reset: released, ALU granted=%b", wr_ready);
    tick();
  endtask

  task automatic test_contention;
    logic [3:0] exp_grant [8];
    logic [3:0] valid_seq [8];
    logic [4:0] exp_addr;
    exp_grant = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b0001, 4'b1000};
    valid_seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1110};
    idle();
    for (int i = 0; i < 4; i++) set_src(i, 5'(10 + i), 32'h111 * (i + 1));
    for (int c = 0; c < 8; c++) begin
      wr_valid = valid_seq[c];
      @(negedge clk);
      total++;
      if (wr_ready !== exp_grant[c])
        begin bad++; $display("FAIL contention_grant[%0d]: got %b expected %b", c, wr_ready, exp_grant[c]); end
      exp_addr = '0;
      for (int i = 0; i < 4; i++) if (exp_grant[c][i]) exp_addr = 5'(10 + i);
      total++;
      if (rf_we !== 1'b1 || rf_addr !== exp_addr)
        begin bad++; $display("FAIL contention_rf[%0d]: got we=%b addr=%0d expected we=1 addr=%0d", c, rf_we, rf_addr, exp_addr); end
      $display("contention: valid=%b grant=%b addr=%0d data=%h", wr_valid, wr_ready, rf_addr, rf_data);
      tick();
    end
    idle();
  endtask

  task automatic test_raw;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_unit = 2'd2;
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL raw_issue_ready: got %b expected 1", issue_ready); end
    tick();
    idle();
    rs1 = 5'd5; rs2 = 5'd5;
    @(negedge clk);
    total++;
    if ({rs1_busy, rs2_busy} !== 2'b11) begin bad++; $display("FAIL raw_busy_set: got %b expected 11", {rs1_busy, rs2_busy}); end
    tick();
    wr_valid = 4'b0100;
    set_src(2, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    total++;
    if (wr_ready !== 4'b0100 || rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL raw_mdu_write: got ready=%b we=%b addr=%0d data=%h expected 0100 1 5 deadbeef", wr_ready, rf_we, rf_addr, rf_data); end
    total++;
    if (rs1_busy !== 1'b1) begin bad++; $display("FAIL raw_busy_same_cycle: got %b expected 1", rs1_busy); end
    tick();
    wr_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rs1_busy !== 1'b0) begin bad++; $display("FAIL raw_busy_clear: got %b expected 0", rs1_busy); end
    total++;
    if (rf_model[5] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL raw_rf_x5: got %h expected deadbeef", rf_model[5]); end
    $display("raw: x5 busy=%b rf=%h", rs1_busy, rf_model[5]);
    tick();
    idle();
  endtask

  task automatic test_waw;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_unit = 2'd3;
    tick();
    issue_unit = 2'd1;
    wr_valid = 4'b1000;
    set_src(3, 5'd7, 32'h0000_0777);
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b0) begin bad++; $display("FAIL waw_stall_same_cycle: got %b expected 0", issue_ready); end
    total++;
    if (wr_ready !== 4'b1000 || rf_we !== 1'b1) begin bad++; $display("FAIL waw_fpu_write: got ready=%b we=%b expected 1000 1", wr_ready, rf_we); end
    tick();
    wr_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL waw_unblock: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd7;
    wr_valid = 4'b0010;
    set_src(1, 5'd7, 32'h0000_0070);
    @(negedge clk);
    total++;
    if (rs1_busy !== 1'b1) begin bad++; $display("FAIL waw_reissued_busy: got %b expected 1", rs1_busy); end
    tick();
    wr_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rs1_busy !== 1'b0) begin bad++; $display("FAIL waw_lsu_clear: got %b expected 0", rs1_busy); end
    $display("waw: x7 busy=%b after LSU write", rs1_busy);
    tick();
    idle();
  endtask

  task automatic test_owner;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd9; issue_unit = 2'd2;
    tick();
    issue_valid = 1'b0;
    rs2 = 5'd9;
    wr_valid = 4'b0001;
    set_src(0, 5'd9, 32'h0000_0099);
    @(negedge clk);
    total++;
    if (wr_ready !== 4'b0001 || rf_we !== 1'b1) begin bad++; $display("FAIL owner_alu_write: got ready=%b we=%b expected 0001 1", wr_ready, rf_we); end
    tick();
    wr_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rs2_busy !== 1'b1) begin bad++; $display("FAIL owner_nonowner_keeps: got %b expected 1", rs2_busy); end
    total++;
    if (rf_model[9] !== 32'h0000_0099) begin bad++; $display("FAIL owner_rf_x9: got %h expected 00000099", rf_model[9]); end
    tick();
    wr_valid = 4'b0100;
    set_src(2, 5'd9, 32'h0000_0ABC);
    tick();
    wr_valid = 4'b0000;
    @(negedge clk);
    total++;
    if (rs2_busy !== 1'b0) begin bad++; $display("FAIL owner_mdu_clear: got %b expected 0", rs2_busy); end
    total++;
    if (rf_model[9] !== 32'h0000_0ABC) begin bad++; $display("FAIL owner_rf_x9_final: got %h expected 00000abc", rf_model[9]); end
    $display("owner: x9 busy=%b rf=%h", rs2_busy, rf_model[9]);
    tick();
    idle();
  endtask

  task automatic test_x0;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_unit = 2'd1;
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b1) begin bad++; $display("FAIL x0_issue_ready: got %b expected 1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    wr_valid = 4'b0010;
    set_src(1, 5'd0, 32'h0000_1234);
    @(negedge clk);
    total++;
    if (wr_ready !== 4'b0010 || rf_we !== 1'b0)
      begin bad++; $display("FAIL x0_lsu_write: got ready=%b we=%b expected 0010 0", wr_ready, rf_we); end
    total++;
    if (rs1_busy !== 1'b0) begin bad++; $display("FAIL x0_busy: got %b expected 0", rs1_busy); end
    $display("x0: ready=%b we=%b", wr_ready, rf_we);
    tick();
    idle();
  endtask

  task automatic test_back_to_back;
    idle();
    issue_valid = 1'b1; issue_rd = 5'd12; issue_unit = 2'd2;
    tick();
    issue_rd = 5'd13; issue_unit = 2'd3;
    rs1 = 5'd12;
    @(negedge clk);
    total++;
    if (issue_ready !== 1'b1 || rs1_busy !== 1'b1)
      begin bad++; $display("FAIL b2b_second_issue: got ready=%b busy=%b expected 1 1", issue_ready, rs1_busy); end
    tick();
    issue_valid = 1'b0;
    rs2 = 5'd13;
    @(negedge clk);
    total++;
    if ({rs1_busy, rs2_busy} !== 2'b11) begin bad++; $display("FAIL b2b_both_busy: got %b expected 11", {rs1_busy, rs2_busy}); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL b2b_reset_drop: got %b expected 00", {rs1_busy, rs2_busy}); end
    $display("back_to_back: after mid-flight reset busy=%b%b", rs1_busy, rs2_busy);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_contention();
    test_raw();
    test_waw();
    test_owner();
    test_x0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
